gate_multi_multi_seq: RTL and testbench

Parametrised multi-input, multi-output logic gate with a runtime-selectable gate function, a registered result, and a sequential trigger dispatcher. When the gate result changes, the dispatcher pulses the output trigger lines one per cycle, in index order. It supersedes the fixed-function multi-output gates in the wiring simulator and sits between lamp/input wiring and downstream wire nets.

---
 rtl/gate_multi_multi_seq.sv | 215 +++++++++++++++++++++
 tb/tb_gate_multi_multi_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_multi_multi_seq.sv
// gate_multi_multi_seq
//   Multi-input, multi-output logic gate with a runtime-selectable function,
//   a registered result and a sequential trigger dispatcher. When the
//   registered result changes, trig pulses one line per cycle in index order.
//   Changes that arrive during a round coalesce into one follow-on round.
//
//   Optional feature macro: GATE_FIRE_COUNT_EN
//     Defined   -> adds output fire_count[15:0], a saturating count of
//                  completed dispatch rounds.
//     Undefined -> no fire_count port or counter.
module gate_multi_multi_seq #(
    parameter int INPUT_COUNT  = 2,
    parameter int OUTPUT_COUNT = 2
) (
    input  logic                    clk,
    input  logic                    logic_reset,
    input  logic [2:0]              mode_in,
    input  logic                    mode_we,
    input  logic [INPUT_COUNT-1:0]  in,
    output logic [2:0]              mode,
    output logic [OUTPUT_COUNT-1:0] out,
    output logic [OUTPUT_COUNT-1:0] trig,
`ifdef GATE_FIRE_COUNT_EN
    output logic                    busy,
    output logic [15:0]             fire_count
`else
    output logic                    busy
`endif
);

    // Dispatcher index needs at least one bit even for a single output.
    localparam int IDX_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUTPUT_COUNT - 1);

    // Population count must hold the value INPUT_COUNT itself.
    localparam int CNT_W = $clog2(INPUT_COUNT + 1);

    typedef enum logic [2:0] {
        MODE_AND    = 3'd0,
        MODE_OR     = 3'd1,
        MODE_XOR    = 3'd2,
        MODE_NAND   = 3'd3,
        MODE_NOR    = 3'd4,
        MODE_XNOR   = 3'd5,
        MODE_PARITY = 3'd6,
        MODE_HOLD   = 3'd7
    } gate_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FIRE = 1'b1
    } disp_state_e;

    gate_mode_e         mode_q;
    logic               res_q;
    logic               result_c;
    logic               change_c;
    logic [CNT_W-1:0]   ones_c;
    logic               one_set_c;

    disp_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_q, pend_d;
    logic               round_done_c;

    // ------------------------------------------------------------------
    // Gate evaluation
    // ------------------------------------------------------------------

    // Count set inputs; XOR/XNOR are defined as "exactly one set", not
    // as a reduction XOR, so a real population count is required.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // branch so no path leaves it unassigned (which would infer a latch).
        ones_c = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            ones_c = ones_c + CNT_W'(in[i]);
        end
    end

    assign one_set_c = (ones_c == CNT_W'(1));

    // Select the gate function; HOLD simply feeds the register back.
    always_comb begin
        result_c = res_q;
        unique case (mode_q)
            MODE_AND:    result_c = &in;
            MODE_OR:     result_c = |in;
            MODE_XOR:    result_c = one_set_c;
            MODE_NAND:   result_c = ~(&in);
            MODE_NOR:    result_c = ~(|in);
            MODE_XNOR:   result_c = ~one_set_c;
            MODE_PARITY: result_c = ^in;
            MODE_HOLD:   result_c = res_q;
            default:     result_c = res_q;
        endcase
    end

    // A change is the registered result about to flip at this edge.
    assign change_c = result_c ^ res_q;

    // ------------------------------------------------------------------
    // Mode and result registers
    // ------------------------------------------------------------------

    // Mode register: a write takes effect for evaluation from the next cycle.
    always_ff @(posedge clk or posedge logic_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (logic_reset) begin
            mode_q <= MODE_AND;
        end else if (mode_we) begin
            mode_q <= gate_mode_e'(mode_in);
        end
    end

    // Result register: follows the gate output every edge.
    always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) begin
            res_q <= 1'b0;
        end else begin
            res_q <= result_c;
        end
    end

    // ------------------------------------------------------------------
    // Dispatcher
    // ------------------------------------------------------------------

    // Dispatcher state register: state, firing index and pending flag.
    always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Dispatcher next state: start on a change, walk the index, and either
    // restart immediately (pending or a change on the final edge) or idle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        round_done_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                pend_d = 1'b0;
                if (change_c) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (idx_q == IDX_LAST) begin
                    round_done_c = 1'b1;
                    idx_d        = '0;
                    pend_d       = 1'b0;
                    // A change on the final edge is served by the round
                    // starting now, exactly as a change seen from IDLE.
                    if (pend_q || change_c) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (change_c) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Trigger decode: one-hot of the index while firing, zero when idle.
    always_comb begin
        trig = '0;
        for (int k = 0; k < OUTPUT_COUNT; k++) begin
            trig[k] = (state_q == ST_FIRE) && (idx_q == IDX_W'(k));
        end
    end

`ifdef GATE_FIRE_COUNT_EN
    logic [15:0] fire_cnt_q;

    // Completed-round counter, saturating at all-ones.
    always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) begin
            fire_cnt_q <= '0;
        end else if (round_done_c && (fire_cnt_q != 16'hFFFF)) begin
            fire_cnt_q <= fire_cnt_q + 16'd1;
        end
    end

    assign fire_count = fire_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mode = mode_q;
    assign out  = {OUTPUT_COUNT{res_q}};
    assign busy = (state_q == ST_FIRE);

endmodule

// File: tb/tb_gate_multi_multi_seq.sv
// Self-checking bench for gate_multi_multi_seq with INPUT_COUNT=3,
// OUTPUT_COUNT=3. A behavioural model counts set inputs, applies the
// gate rule, and tracks the dispatcher as "cycles into the current round"
// plus an owed follow-on round.
module tb_gate_multi_multi_seq;

    localparam int IN_N  = 3;
    localparam int OUT_N = 3;

    logic             clk;
    logic             logic_reset;
    logic [2:0]       mode_in;
    logic             mode_we;
    logic [IN_N-1:0]  in;
    logic [2:0]       mode;
    logic [OUT_N-1:0] out;
    logic [OUT_N-1:0] trig;
    logic             busy;
`ifdef GATE_FIRE_COUNT_EN
    logic [15:0]      fire_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode;
    bit m_res;
    int m_phase;      // cycle within current round, -1 when no round runs
    bit m_owed;       // a follow-on round has been requested
    int m_rounds;     // completed rounds (saturating at 65535)

    gate_multi_multi_seq #(
        .INPUT_COUNT (IN_N),
        .OUTPUT_COUNT(OUT_N)
    ) dut (
        .clk        (clk),
        .logic_reset(logic_reset),
        .mode_in    (mode_in),
        .mode_we    (mode_we),
        .in         (in),
        .mode       (mode),
        .out        (out),
        .trig       (trig),
`ifdef GATE_FIRE_COUNT_EN
        .busy       (busy),
        .fire_count (fire_count)
`else
        .busy       (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_gate(int m, int n, bit held);
        case (m)
            0:       return n == IN_N;
            1:       return n >= 1;
            2:       return n == 1;
            3:       return n != IN_N;
            4:       return n == 0;
            5:       return n != 1;
            6:       return (n % 2) == 1;
            default: return held;
        endcase
    endfunction

    function automatic logic [OUT_N-1:0] exp_trig();
        logic [OUT_N-1:0] v;
        v = '0;
        if (m_phase >= 0) v[m_phase] = 1'b1;
        return v;
    endfunction

    function automatic logic [OUT_N-1:0] exp_out();
        return m_res ? {OUT_N{1'b1}} : {OUT_N{1'b0}};
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_res    = 1'b0;
        m_phase  = -1;
        m_owed   = 1'b0;
        m_rounds = 0;
    endtask

    // Advance one clock: update the model from pre-edge inputs, then sample #1 later.
    task automatic tick();
        bit r;
        bit chg;
        r   = ref_gate(m_mode, $countones(in), m_res);
        chg = (r != m_res);
        if (m_phase < 0) begin
            if (chg) m_phase = 0;
        end else if (m_phase == OUT_N - 1) begin
            if (m_rounds < 65535) m_rounds++;
            m_phase = (m_owed || chg) ? 0 : -1;
            m_owed  = 1'b0;
        end else begin
            m_phase++;
            if (chg) m_owed = 1'b1;
        end
        m_res = r;
        if (mode_we) m_mode = int'(mode_in);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_phase >= 0; i++) tick();
    endtask

    task automatic test_reset();
        logic_reset = 1'b1;
        mode_in = 3'd0;
        mode_we = 1'b0;
        in      = '0;
        model_reset();
        #12;
        checks++; if (out !== 3'b000) begin errors++; $display("FAIL reset_out: got %b expected 000", out); end
        checks++; if (trig !== 3'b000) begin errors++; $display("FAIL reset_trig: got %b expected 000", trig); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
`ifdef GATE_FIRE_COUNT_EN
        checks++; if (fire_count !== 16'd0) begin errors++; $display("FAIL reset_fire_count: got %0d expected 0", fire_count); end
`endif
        logic_reset = 1'b0;
    endtask

    task automatic test_xnor_dispatch();
        logic [OUT_N-1:0] seen [4];
        logic [OUT_N-1:0] want [4];
        int busy_cycles;
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b000;
        mode_in = 3'd5; mode_we = 1'b1; in = 3'b000;
        tick();
        mode_we = 1'b0;
        checks++; if (out !== 3'b000) begin errors++; $display("FAIL xnor_load_out: got %b expected 000", out); end
        tick();
        checks++; if (out !== 3'b111) begin errors++; $display("FAIL xnor_out: got %b expected 111", out); end
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            seen[i] = trig;
            if (busy === 1'b1) busy_cycles++;
            if (i < 3) tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin errors++; $display("FAIL xnor_trig[%0d]: got %b expected %b", i, seen[i], want[i]); end
        end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL xnor_busy_cycles: got %0d expected 3", busy_cycles); end
    endtask

    task automatic test_xor_two_rounds();
        int busy_cycles;
        mode_in = 3'd2; mode_we = 1'b1; in = 3'b000;
        tick();
        mode_we = 1'b0;
        drain();
        tick();
        drain();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL xor_idle: got %b expected 0", busy); end
        in = 3'b001;
        tick();
        checks++; if (out !== 3'b111) begin errors++; $display("FAIL xor_out_one: got %b expected 111", out); end
        checks++; if (trig !== 3'b001) begin errors++; $display("FAIL xor_trig_first: got %b expected 001", trig); end
        drain();
        in = 3'b011;
        tick();
        checks++; if (out !== 3'b000) begin errors++; $display("FAIL xor_out_two: got %b expected 000", out); end
        busy_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL xor_second_round_len: got %0d expected 3", busy_cycles); end
    endtask

    task automatic test_back_to_back();
        logic [OUT_N-1:0] seen [7];
        logic [OUT_N-1:0] want [7];
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100;
        want[3] = 3'b001; want[4] = 3'b010; want[5] = 3'b100; want[6] = 3'b000;
        in = 3'b000;
        tick();
        drain();
        in = 3'b001;
        tick();
        seen[0] = trig;
        in = 3'b011;
        tick();
        seen[1] = trig;
        in = 3'b001;
        for (int i = 2; i < 7; i++) begin
            tick();
            seen[i] = trig;
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin errors++; $display("FAIL coalesce_trig[%0d]: got %b expected %b", i, seen[i], want[i]); end
        end
    endtask

    task automatic test_reset_mid_fire();
        bit found;
        int stray;
        in = 3'b000;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (trig === 3'b010) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midfire_wait: got no trig=010 within 10 cycles, expected one"); end
        logic_reset = 1'b1;
        #1;
        model_reset();
        checks++; if (trig !== 3'b000) begin errors++; $display("FAIL midfire_trig: got %b expected 000", trig); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midfire_busy: got %b expected 0", busy); end
        checks++; if (out !== 3'b000) begin errors++; $display("FAIL midfire_out: got %b expected 000", out); end
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL midfire_mode: got %0d expected 0", mode); end
        logic_reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (trig !== 3'b000 || busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL midfire_after_release: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_hold();
        int bad;
        mode_in = 3'd4; mode_we = 1'b1; in = 3'b000;
        tick();
        mode_we = 1'b0;
        tick();
        drain();
        mode_in = 3'd7; mode_we = 1'b1;
        tick();
        mode_we = 1'b0;
        drain();
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL hold_mode: got %0d expected 7", mode); end
        checks++; if (out !== 3'b111) begin errors++; $display("FAIL hold_start_out: got %b expected 111", out); end
        bad = 0;
        for (int v = 0; v < 8; v++) begin
            in = 3'(v);
            tick();
            if (out !== 3'b111 || trig !== 3'b000 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_sweep: got %0d disturbed cycles expected 0", bad); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in      = 3'($urandom_range(0, 7));
            mode_we = ($urandom_range(0, 9) == 0);
            mode_in = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (out !== exp_out() || trig !== exp_trig() || busy !== (m_phase >= 0) || mode !== 3'(m_mode)) begin
                errors++;
                $display("FAIL random[%0d]: got out=%b trig=%b busy=%b mode=%0d expected out=%b trig=%b busy=%b mode=%0d",
                         i, out, trig, busy, mode, exp_out(), exp_trig(), (m_phase >= 0), m_mode);
            end
`ifdef GATE_FIRE_COUNT_EN
            checks++;
            if (fire_count !== 16'(m_rounds)) begin
                errors++;
                $display("FAIL random_fire_count[%0d]: got %0d expected %0d", i, fire_count, m_rounds);
            end
`endif
        end
        mode_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_xnor_dispatch();
        test_xor_two_rounds();
        test_back_to_back();
        test_reset_mid_fire();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
